// File: rtl/xmodem_tx.sv
// XMODEM (checksum) sender: streams a memory byte range as 128-byte packets
// over the UART FIFOs, with host-driven retry, CAN abort and EOT handshake.
module xmodem_tx #(
  parameter int                    NB_UART_DATA = 8,
  parameter int                    NB_ADDR      = 10,
  parameter int                    NB_LEN       = 16,
  parameter int                    MAX_RETRY    = 10,
  parameter int                    NB_TIMEOUT   = 24,
  parameter logic [NB_TIMEOUT-1:0] TIMEOUT_CYC  = 24'd5_000_000
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [NB_ADDR-1:0]      i_base_addr,
  input  logic [NB_LEN-1:0]       i_len,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error,
  output logic                    o_mem_rd,
  output logic [NB_ADDR-1:0]      o_mem_addr,
  input  logic [7:0]              i_mem_data,
  output logic                    o_uart_wr,
  output logic                    o_uart_tx_start,
  output logic [NB_UART_DATA-1:0] o_uart_wdata,
  input  logic                    i_uart_tx_done,
  output logic                    o_uart_rd,
  input  logic [NB_UART_DATA-1:0] i_uart_rx_data,
  input  logic                    i_uart_rx_done
);

  localparam int                    NB_RETRY   = $clog2(MAX_RETRY + 1);
  localparam logic [NB_RETRY-1:0]   RETRY_LAST = NB_RETRY'(MAX_RETRY - 1);
  localparam logic [NB_TIMEOUT-1:0] TMO_LAST   = TIMEOUT_CYC - NB_TIMEOUT'(1);
  localparam logic [7:0] B_SOH = 8'h01, B_EOT = 8'h04, B_ACK = 8'h06;
  localparam logic [7:0] B_NAK = 8'h15, B_CAN = 8'h18, B_PAD = 8'h1A;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_NAK, S_SEND_SOH, S_SEND_BLK, S_SEND_NBLK, S_SEND_DATA,
    S_SEND_CKSUM, S_WAIT_RESP, S_SEND_EOT, S_WAIT_EOT_ACK, S_DONE, S_ERR
  } state_t;

  state_t                state, state_n, send_next;
  logic                  sent, sent_n, is_send, retry_last, timeout;
  logic [NB_ADDR-1:0]    base_q, base_n;
  logic [NB_LEN-1:0]     len_q, len_n;
  logic [NB_LEN:0]       off_q, off_n;
  logic [6:0]            idx_q, idx_n, nidx;
  logic [7:0]            blk_q, blk_n, cksum_q, cksum_n, tx_byte, rx_byte_q;
  logic [NB_RETRY-1:0]   retry_q, retry_n;
  logic [NB_TIMEOUT-1:0] timer_q, timer_n;
  logic                  rx_vld_q;

  // off is one bit wider than len so the last packet's compare cannot overflow
  function automatic logic in_range(input logic [NB_LEN:0] off, input logic [6:0] idx,
                                    input logic [NB_LEN-1:0] len);
    return (off + (NB_LEN+1)'(idx)) < {1'b0, len};
  endfunction

  always_comb begin
    state_n = state;  sent_n = sent;   base_n = base_q;  len_n = len_q;
    off_n = off_q;    idx_n = idx_q;   blk_n = blk_q;    cksum_n = cksum_q;
    retry_n = retry_q;
    timer_n = '0;
    tx_byte = 8'h00;  send_next = state;  is_send = 1'b0;
    o_mem_rd = 1'b0;  o_mem_addr = '0;  o_uart_wr = 1'b0;  o_uart_wdata = '0;
    o_done = 1'b0;    o_error = 1'b0;
    o_busy = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);
    retry_last = (retry_q == RETRY_LAST);
    timeout = (timer_q == TMO_LAST);
    nidx = (state == S_SEND_NBLK) ? 7'd0 : idx_q + 7'd1;
    case (state)
      S_IDLE: if (i_start) begin
        base_n = i_base_addr;  len_n = i_len;  off_n = '0;
        blk_n = 8'h01;  retry_n = '0;  state_n = S_WAIT_NAK;
      end
      S_WAIT_NAK: begin
        timer_n = timer_q + 1'b1;
        if (rx_vld_q && rx_byte_q == B_NAK) begin
          retry_n = '0;  timer_n = '0;
          state_n = (len_q == '0) ? S_SEND_EOT : S_SEND_SOH;
        end else if (timeout) begin
          timer_n = '0;
          if (retry_last) state_n = S_ERR;
          else            retry_n = retry_q + 1'b1;
        end
      end
      S_SEND_SOH:   begin is_send = 1'b1; tx_byte = B_SOH;  send_next = S_SEND_BLK;
                          cksum_n = '0; idx_n = '0; end
      S_SEND_BLK:   begin is_send = 1'b1; tx_byte = blk_q;  send_next = S_SEND_NBLK; end
      S_SEND_NBLK:  begin is_send = 1'b1; tx_byte = ~blk_q; send_next = S_SEND_DATA; end
      S_SEND_DATA:  begin
        is_send = 1'b1;
        tx_byte = in_range(off_q, idx_q, len_q) ? i_mem_data : B_PAD;
        send_next = (idx_q == 7'd127) ? S_SEND_CKSUM : S_SEND_DATA;
      end
      S_SEND_CKSUM: begin is_send = 1'b1; tx_byte = cksum_q; send_next = S_WAIT_RESP; end
      S_SEND_EOT:   begin is_send = 1'b1; tx_byte = B_EOT;   send_next = S_WAIT_EOT_ACK; end
      S_WAIT_RESP: begin
        timer_n = timer_q + 1'b1;
        if (rx_vld_q && rx_byte_q == B_ACK) begin
          blk_n = blk_q + 8'd1;  off_n = off_q + (NB_LEN+1)'(128);
          retry_n = '0;  timer_n = '0;
          state_n = (off_n >= {1'b0, len_q}) ? S_SEND_EOT : S_SEND_SOH;
        end else if (rx_vld_q && rx_byte_q == B_CAN) begin
          state_n = S_ERR;
        end else if ((rx_vld_q && rx_byte_q == B_NAK) || timeout) begin
          timer_n = '0;
          if (retry_last) state_n = S_ERR;
          else begin retry_n = retry_q + 1'b1; state_n = S_SEND_SOH; end
        end
      end
      S_WAIT_EOT_ACK: begin
        timer_n = timer_q + 1'b1;
        if (rx_vld_q && rx_byte_q == B_ACK) begin
          state_n = S_DONE;
        end else if ((rx_vld_q && rx_byte_q == B_NAK) || timeout) begin
          timer_n = '0;
          if (retry_last) state_n = S_ERR;
          else begin retry_n = retry_q + 1'b1; state_n = S_SEND_EOT; end
        end
      end
      S_DONE:  begin o_done = 1'b1;  state_n = S_IDLE; end
      S_ERR:   begin o_error = 1'b1; state_n = S_IDLE; end
      default: state_n = S_IDLE;
    endcase
    // Shared byte send: one write cycle, then hold until the line reports done.
    // The next payload byte is fetched on the done cycle so it is ready on entry.
    if (is_send) begin
      if (!sent) begin
        o_uart_wr = 1'b1;
        o_uart_wdata = NB_UART_DATA'(tx_byte);
        sent_n = 1'b1;
        if (state == S_SEND_DATA) cksum_n = cksum_q + tx_byte;
      end else if (i_uart_tx_done) begin
        sent_n = 1'b0;
        state_n = send_next;
        if (state == S_SEND_DATA) idx_n = nidx;
        if (send_next == S_SEND_DATA && in_range(off_q, nidx, len_q)) begin
          o_mem_rd = 1'b1;
          o_mem_addr = base_q + NB_ADDR'(off_q + (NB_LEN+1)'(nidx));
        end
      end
    end
  end

  assign o_uart_tx_start = o_uart_wr;
  assign o_uart_rd       = rx_vld_q;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state <= S_IDLE;   sent <= 1'b0;    base_q <= '0;   len_q <= '0;
      off_q <= '0;       idx_q <= '0;     blk_q <= '0;    cksum_q <= '0;
      retry_q <= '0;     timer_q <= '0;   rx_vld_q <= 1'b0; rx_byte_q <= '0;
    end else begin
      state <= state_n;  sent <= sent_n;  base_q <= base_n; len_q <= len_n;
      off_q <= off_n;    idx_q <= idx_n;  blk_q <= blk_n;   cksum_q <= cksum_n;
      retry_q <= retry_n; timer_q <= timer_n;
      rx_vld_q <= i_uart_rx_done;
      rx_byte_q <= i_uart_rx_data[7:0];
    end
  end

endmodule
